// File: rtl/up_sample_pkg.sv
// Shared definitions for the integer-ratio upsampler: ratio encoding,
// ratio-to-last-phase helper and the output FSM state type.
package up_sample_pkg;

    localparam logic [1:0] RATIO_X1 = 2'b00;
    localparam logic [1:0] RATIO_X2 = 2'b01;
    localparam logic [1:0] RATIO_X4 = 2'b10;
    localparam logic [1:0] RATIO_X8 = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Index of the final beat of a burst (N-1 for N = 1 << ratio).
    function automatic logic [2:0] ratio_to_last_phase(input logic [1:0] ratio);
        logic [2:0] last;
        case (ratio)
            RATIO_X1: last = 3'd0;
            RATIO_X2: last = 3'd1;
            RATIO_X4: last = 3'd3;
            RATIO_X8: last = 3'd7;
            default:  last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/up_sample_pend.sv
// One-entry pending register holding a sample together with its captured
// ratio and hold mode. A load on the same edge as an unload wins, so the
// entry stays full with the new sample.
module up_sample_pend
    import up_sample_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_ratio,
    input  logic                  i_hold,
    input  logic                  i_unload,
    output logic                  o_full,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_ratio,
    output logic                  o_hold
);

    logic                  full_d,  full_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;
    logic [1:0]            ratio_d, ratio_q;
    logic                  hold_d,  hold_q;

    // Next-state: capture on load, drop the full flag on a bare unload.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        ratio_d = ratio_q;
        hold_d  = hold_q;
        if (i_load) begin
            full_d  = 1'b1;
            data_d  = i_data;
            ratio_d = i_ratio;
            hold_d  = i_hold;
        end else if (i_unload) begin
            full_d  = 1'b0;
        end else begin
            full_d  = full_q;
        end
    end

    // Pending entry flops with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q  <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            ratio_q <= RATIO_X1;
            hold_q  <= 1'b0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            ratio_q <= ratio_d;
            hold_q  <= hold_d;
        end
    end

    assign o_full  = full_q;
    assign o_data  = data_q;
    assign o_ratio = ratio_q;
    assign o_hold  = hold_q;

endmodule

// File: rtl/up_sample.sv
// Integer-ratio upsampler: each accepted sample becomes a burst of 1/2/4/8
// output beats, extra beats either zero-stuffed or zero-order held.
module up_sample
    import up_sample_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_ratio,
    input  logic                  i_hold,
    output logic                  o_in_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_first,
    input  logic                  i_out_ready,
    output logic                  o_busy
);

    logic                  pend_full_s;
    logic [DATA_WIDTH-1:0] pend_data_s;
    logic [1:0]            pend_ratio_s;
    logic                  pend_hold_s;
    logic                  pend_load_s;
    logic                  pend_unload_s;
    logic                  last_s;

    state_t                state_d,    state_q;
    logic [2:0]            phase_d,    phase_q;
    logic [DATA_WIDTH-1:0] cur_data_d, cur_data_q;
    logic [1:0]            cur_ratio_d, cur_ratio_q;
    logic                  cur_hold_d, cur_hold_q;
    logic [DATA_WIDTH-1:0] o_data_d,   o_data_q;
    logic                  o_first_d,  o_first_q;

    up_sample_pend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pend (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (pend_load_s),
        .i_data   (i_data),
        .i_ratio  (i_ratio),
        .i_hold   (i_hold),
        .i_unload (pend_unload_s),
        .o_full   (pend_full_s),
        .o_data   (pend_data_s),
        .o_ratio  (pend_ratio_s),
        .o_hold   (pend_hold_s)
    );

    assign last_s = (phase_q == ratio_to_last_phase(cur_ratio_q));

    // Pending drains into the output stage when idle or on the final beat
    // handshake; the ready path from i_out_ready is deliberately combinational
    // so bursts and samples chain without bubbles.
    always_comb begin
        pend_unload_s = 1'b0;
        if (pend_full_s && ((state_q == IDLE) ||
                            ((state_q == EMIT) && last_s && i_out_ready))) begin
            pend_unload_s = 1'b1;
        end else begin
            pend_unload_s = 1'b0;
        end
    end

    assign o_in_ready  = !i_rst && (!pend_full_s || pend_unload_s);
    assign pend_load_s = i_valid && o_in_ready;

    // Output FSM next-state: burst loading, phase stepping and output mux.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cur_data_d  = cur_data_q;
        cur_ratio_d = cur_ratio_q;
        cur_hold_d  = cur_hold_q;
        o_data_d    = o_data_q;
        o_first_d   = o_first_q;
        case (state_q)
            IDLE: begin
                if (pend_full_s) begin
                    state_d     = EMIT;
                    phase_d     = 3'd0;
                    cur_data_d  = pend_data_s;
                    cur_ratio_d = pend_ratio_s;
                    cur_hold_d  = pend_hold_s;
                    o_data_d    = pend_data_s;
                    o_first_d   = 1'b1;
                end else begin
                    o_data_d    = {DATA_WIDTH{1'b0}};
                    o_first_d   = 1'b0;
                end
            end
            EMIT: begin
                if (!i_out_ready) begin
                    // Stalled: beat, phase and marker stay frozen.
                    state_d = EMIT;
                end else if (!last_s) begin
                    phase_d   = phase_q + 3'd1;
                    o_data_d  = cur_hold_q ? cur_data_q : {DATA_WIDTH{1'b0}};
                    o_first_d = 1'b0;
                end else if (pend_full_s) begin
                    phase_d     = 3'd0;
                    cur_data_d  = pend_data_s;
                    cur_ratio_d = pend_ratio_s;
                    cur_hold_d  = pend_hold_s;
                    o_data_d    = pend_data_s;
                    o_first_d   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    phase_d   = 3'd0;
                    o_data_d  = {DATA_WIDTH{1'b0}};
                    o_first_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                phase_d   = 3'd0;
                o_data_d  = {DATA_WIDTH{1'b0}};
                o_first_d = 1'b0;
            end
        endcase
    end

    // FSM, burst context and registered output flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            phase_q     <= 3'd0;
            cur_data_q  <= {DATA_WIDTH{1'b0}};
            cur_ratio_q <= RATIO_X1;
            cur_hold_q  <= 1'b0;
            o_data_q    <= {DATA_WIDTH{1'b0}};
            o_first_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cur_data_q  <= cur_data_d;
            cur_ratio_q <= cur_ratio_d;
            cur_hold_q  <= cur_hold_d;
            o_data_q    <= o_data_d;
            o_first_q   <= o_first_d;
        end
    end

    assign o_valid = (state_q == EMIT);
    assign o_data  = o_data_q;
    assign o_first = o_first_q;
    assign o_busy  = pend_full_s || (state_q == EMIT);

endmodule

// File: tb/tb_up_sample.sv
// Directed bench for up_sample: per-cycle vector table plus hand sequences
// for stalled bursts and reset in the middle of a burst.
module tb_up_sample;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic [1:0]  i_ratio;
    logic        i_hold;
    logic        o_in_ready;
    logic        o_valid;
    logic [15:0] o_data;
    logic        o_first;
    logic        i_out_ready;
    logic        o_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic [1:0]  ratio;
        logic        hold;
        logic        ordy;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_first;
        logic        e_inrdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    up_sample #(.DATA_WIDTH(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_ratio     (i_ratio),
        .i_hold      (i_hold),
        .o_in_ready  (o_in_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_first     (o_first),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic void add(input logic rst, input logic vld, input logic [15:0] d,
                                input logic [1:0] r, input logic h, input logic ordy,
                                input logic ev, input logic [15:0] ed, input logic ef,
                                input logic er, input logic eb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.data = d; v.ratio = r; v.hold = h; v.ordy = ordy;
        v.e_valid = ev; v.e_data = ed; v.e_first = ef; v.e_inrdy = er; v.e_busy = eb;
        vecs.push_back(v);
    endfunction

    initial begin
        int beats;
        int vcount;

        i_rst = 1'b1; i_valid = 1'b0; i_data = 16'h0; i_ratio = 2'd0;
        i_hold = 1'b0; i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);

        // x2 zero-stuff single sample
        add(1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0,  1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 16'h1234, 2'd1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // x4 hold, 0005 then 0007 back-to-back
        add(1'b0, 1'b1, 16'h0005, 2'd2, 1'b1, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 16'h0007, 2'd2, 1'b1, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0005, 1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0005, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0007, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0007, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0007, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b1, 16'h0007, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // 00AA at x8, ratio switched to x2 for 00BB while AA is queued
        add(1'b0, 1'b1, 16'h00AA, 2'd3, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 16'h00BB, 2'd1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h00BB, 1'b1, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        // x1 ramp 0..9 streamed at full rate
        for (int k = 0; k < 13; k++) begin
            logic ev;
            ev = (k >= 2) && (k <= 11);
            add(1'b0, (k < 10), (k < 10) ? 16'(k) : 16'h0000, 2'd0, 1'b1, 1'b1,
                ev, ev ? 16'(k - 2) : 16'h0000, ev, 1'b1, (k >= 1) && (k <= 11));
        end

        foreach (vecs[i]) begin
            @(negedge i_clk);
            i_rst = vecs[i].rst; i_valid = vecs[i].vld; i_data = vecs[i].data;
            i_ratio = vecs[i].ratio; i_hold = vecs[i].hold; i_out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d valid", i), 16'(o_valid),    16'(vecs[i].e_valid));
            chk($sformatf("v%0d data", i),  o_data,          vecs[i].e_data);
            chk($sformatf("v%0d first", i), 16'(o_first),    16'(vecs[i].e_first));
            chk($sformatf("v%0d inrdy", i), 16'(o_in_ready), 16'(vecs[i].e_inrdy));
            chk($sformatf("v%0d busy", i),  16'(o_busy),     16'(vecs[i].e_busy));
        end

        // x8 zero-stuff FFFF with i_out_ready toggling every cycle
        @(negedge i_clk);
        i_valid = 1'b1; i_data = 16'hFFFF; i_ratio = 2'd3; i_hold = 1'b0; i_out_ready = 1'b0;
        #1;
        chk("x8tog accept", 16'(o_in_ready), 16'h0001);
        @(negedge i_clk);
        i_valid = 1'b0;
        beats = 0;
        for (int c = 0; c < 60 && beats < 8; c++) begin
            if (c > 0) @(negedge i_clk);
            i_out_ready = c[0];
            #1;
            if (o_valid) begin
                chk($sformatf("x8tog data b%0d", beats), o_data,
                    (beats == 0) ? 16'hFFFF : 16'h0000);
                chk($sformatf("x8tog first b%0d", beats), 16'(o_first),
                    (beats == 0) ? 16'h0001 : 16'h0000);
                if (i_out_ready) beats++;
            end
        end
        chk("x8tog beat count", 16'(beats), 16'd8);
        @(negedge i_clk);
        i_out_ready = 1'b1;
        #1;
        chk("x8tog done valid", 16'(o_valid), 16'h0000);
        chk("x8tog done busy", 16'(o_busy), 16'h0000);

        // reset at phase 3 of an x8 burst with a pending sample
        @(negedge i_clk);
        i_valid = 1'b1; i_data = 16'h0011; i_ratio = 2'd3; i_hold = 1'b1;
        @(negedge i_clk);
        i_data = 16'h0022;
        #1;
        chk("rst pend accept", 16'(o_in_ready), 16'h0001);
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        chk("rst burst first", 16'(o_first), 16'h0001);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("rst ph3 valid", 16'(o_valid), 16'h0001);
        chk("rst ph3 data", o_data, 16'h0011);
        chk("rst ph3 inrdy", 16'(o_in_ready), 16'h0000);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst after valid", 16'(o_valid), 16'h0000);
        chk("rst after data", o_data, 16'h0000);
        chk("rst after busy", 16'(o_busy), 16'h0000);
        chk("rst after inrdy", 16'(o_in_ready), 16'h0001);
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            #1;
            if (o_valid || o_busy) vcount++;
        end
        chk("rst silent cycles", 16'(vcount), 16'h0000);
        @(negedge i_clk);
        i_valid = 1'b1; i_data = 16'h0033; i_ratio = 2'd0;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        #1;
        chk("rst new valid", 16'(o_valid), 16'h0001);
        chk("rst new data", o_data, 16'h0033);
        chk("rst new first", 16'(o_first), 16'h0001);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
